// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Shares one Avalon-style memory bus between instruction fetch
//               and data load/store, data-first with a fetch starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================

module mips_bus_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,

  // Instruction-fetch requester
  input  logic [31:0] if_address,
  input  logic        if_read,
  output logic        if_waitrequest,
  output logic [31:0] if_readdata,

  // Data-memory requester
  input  logic [31:0] dm_address,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_writedata,
  input  logic [3:0]  dm_byteenable,
  output logic        dm_waitrequest,
  output logic [31:0] dm_readdata,

  // Shared memory bus
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int unsigned              c_CNT_W    = $clog2(MAX_DATA_RUN + 1);
  localparam logic [c_CNT_W-1:0]       c_RUN_MAX  = c_CNT_W'(MAX_DATA_RUN);
  localparam logic [c_CNT_W-1:0]       c_RUN_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_RDATA = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;

  logic [c_CNT_W-1:0] r_run_cnt;
  logic               r_sel_dm;
  logic               r_is_write;

  logic [31:0]        r_address;
  logic               r_read;
  logic               r_write;
  logic [31:0]        r_writedata;
  logic [3:0]         r_byteenable;
  logic               r_if_wait;
  logic               r_dm_wait;
  logic [31:0]        r_if_readdata;
  logic [31:0]        r_dm_readdata;

  logic               w_dm_req;
  logic               w_grant_dm;
  logic               w_grant_if;
  logic               w_read_nxt;
  logic               w_write_nxt;
  logic               w_done_nxt;
  logic               w_capture;
  logic               w_if_wait_nxt;
  logic               w_dm_wait_nxt;

  // Data wins unless fetch is waiting and data has already had its run.
  assign w_dm_req   = dm_read | dm_write;
  assign w_grant_dm = (r_state == c_ST_IDLE) && w_dm_req &&
                      (!if_read || (r_run_cnt < c_RUN_MAX));
  assign w_grant_if = (r_state == c_ST_IDLE) && !w_grant_dm && if_read;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_grant_dm || w_grant_if) begin
          w_state_nxt = c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        if (!waitrequest) begin
          w_state_nxt = r_is_write ? c_ST_DONE : c_ST_RDATA;
        end
      end
      c_ST_RDATA: w_state_nxt = c_ST_DONE;
      c_ST_DONE:  w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: next values for the registered bus and port outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_read_nxt  = 1'b0;
    w_write_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_read_nxt  = w_grant_if || (w_grant_dm && !dm_write);
        w_write_nxt = w_grant_dm && dm_write;
      end
      c_ST_ISSUE: begin
        w_read_nxt  = r_read  && waitrequest;
        w_write_nxt = r_write && waitrequest;
        w_done_nxt  = !waitrequest && r_is_write;
      end
      c_ST_RDATA: begin
        w_done_nxt = 1'b1;
        w_capture  = 1'b1;
      end
      default: begin
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
      end
    endcase
    w_if_wait_nxt = !(w_done_nxt && !r_sel_dm);
    w_dm_wait_nxt = !(w_done_nxt &&  r_sel_dm);
  end

  // --------------------------------------------------------------------------
  // Request latch, run counter and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_address     <= 32'd0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_writedata   <= 32'd0;
      r_byteenable  <= 4'd0;
      r_if_wait     <= 1'b1;
      r_dm_wait     <= 1'b1;
      r_if_readdata <= 32'd0;
      r_dm_readdata <= 32'd0;
      r_sel_dm      <= 1'b0;
      r_is_write    <= 1'b0;
      r_run_cnt     <= '0;
    end else begin
      r_read    <= w_read_nxt;
      r_write   <= w_write_nxt;
      r_if_wait <= w_if_wait_nxt;
      r_dm_wait <= w_dm_wait_nxt;

      if (w_grant_dm) begin
        r_address    <= dm_address;
        r_writedata  <= dm_writedata;
        r_byteenable <= dm_byteenable;
        r_sel_dm     <= 1'b1;
        r_is_write   <= dm_write;
        // A data run only counts against a fetch that is actually waiting.
        if (!if_read) begin
          r_run_cnt <= '0;
        end else if (r_run_cnt != c_RUN_MAX) begin
          r_run_cnt <= r_run_cnt + c_RUN_ONE;
        end
      end else if (w_grant_if) begin
        r_address    <= if_address;
        r_writedata  <= 32'd0;
        r_byteenable <= 4'b1111;
        r_sel_dm     <= 1'b0;
        r_is_write   <= 1'b0;
        r_run_cnt    <= '0;
      end

      if (w_capture) begin
        if (r_sel_dm) begin
          r_dm_readdata <= readdata;
        end else begin
          r_if_readdata <= readdata;
        end
      end
    end
  end

  assign address        = r_address;
  assign read           = r_read;
  assign write          = r_write;
  assign writedata      = r_writedata;
  assign byteenable     = r_byteenable;
  assign if_waitrequest = r_if_wait;
  assign dm_waitrequest = r_dm_wait;
  assign if_readdata    = r_if_readdata;
  assign dm_readdata    = r_dm_readdata;

endmodule

`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Directed self-checking bench for mips_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mips_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] if_address;
  logic        if_read;
  logic        if_waitrequest;
  logic [31:0] if_readdata;
  logic [31:0] dm_address;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_writedata;
  logic [3:0]  dm_byteenable;
  logic        dm_waitrequest;
  logic [31:0] dm_readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [31:0] mem [16];

  int n_compared;
  int n_mismatch;

  mips_bus_arbiter #(.MAX_DATA_RUN(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_address     (if_address),
    .if_read        (if_read),
    .if_waitrequest (if_waitrequest),
    .if_readdata    (if_readdata),
    .dm_address     (dm_address),
    .dm_read        (dm_read),
    .dm_write       (dm_write),
    .dm_writedata   (dm_writedata),
    .dm_byteenable  (dm_byteenable),
    .dm_waitrequest (dm_waitrequest),
    .dm_readdata    (dm_readdata),
    .address        (address),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .byteenable     (byteenable),
    .waitrequest    (waitrequest),
    .readdata       (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: 16 words, read data returned the cycle after acceptance.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'd0;
      mem[0]   <= 32'h3C08BFC0;
      mem[1]   <= 32'hAAAA0001;
      mem[2]   <= 32'hDDDD0002;
      mem[3]   <= 32'h5555AAAA;
      mem[12]  <= 32'h11223344;
      readdata <= 32'd0;
    end else begin
      if (read && !waitrequest) readdata <= mem[address[5:2]];
      if (write && !waitrequest) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) mem[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatch++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] rec [6];
  int          n_rec;
  logic        prev_read;

  initial begin
    n_compared    = 0;
    n_mismatch    = 0;
    reset         = 1'b1;
    if_address    = 32'd0;
    if_read       = 1'b0;
    dm_address    = 32'd0;
    dm_read       = 1'b0;
    dm_write      = 1'b0;
    dm_writedata  = 32'd0;
    dm_byteenable = 4'd0;
    waitrequest   = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_read",   {31'd0, read},           32'd0);
    check("rst_write",  {31'd0, write},          32'd0);
    check("rst_addr",   address,                 32'd0);
    check("rst_wdata",  writedata,               32'd0);
    check("rst_be",     {28'd0, byteenable},     32'd0);
    check("rst_ifwait", {31'd0, if_waitrequest}, 32'd1);
    check("rst_dmwait", {31'd0, dm_waitrequest}, 32'd1);
    check("rst_ifrd",   if_readdata,             32'd0);
    check("rst_dmrd",   dm_readdata,             32'd0);
    reset = 1'b0;
    tick();

    // Fetch only
    if_address = 32'hBFC00000;
    if_read    = 1'b1;
    tick();
    check("f_read_t1",  {31'd0, read},           32'd1);
    check("f_addr_t1",  address,                 32'hBFC00000);
    check("f_ifw_t1",   {31'd0, if_waitrequest}, 32'd1);
    tick();
    check("f_read_t2",  {31'd0, read},           32'd0);
    check("f_ifw_t2",   {31'd0, if_waitrequest}, 32'd1);
    tick();
    check("f_ifw_t3",   {31'd0, if_waitrequest}, 32'd0);
    check("f_ifrd_t3",  if_readdata,             32'h3C08BFC0);
    check("f_dmw_t3",   {31'd0, dm_waitrequest}, 32'd1);
    if_read = 1'b0;
    tick();
    check("f_ifw_t4",   {31'd0, if_waitrequest}, 32'd1);

    // Store halfword to word 12
    dm_address    = 32'hBFC00030;
    dm_writedata  = 32'h0000A3F3;
    dm_byteenable = 4'b1100;
    dm_write      = 1'b1;
    tick();
    check("sh_write_t1", {31'd0, write},          32'd1);
    check("sh_read_t1",  {31'd0, read},           32'd0);
    check("sh_be_t1",    {28'd0, byteenable},     32'hC);
    check("sh_addr_t1",  address,                 32'hBFC00030);
    check("sh_wdata_t1", writedata,               32'h0000A3F3);
    tick();
    check("sh_dmw_t2",   {31'd0, dm_waitrequest}, 32'd0);
    check("sh_write_t2", {31'd0, write},          32'd0);
    dm_write = 1'b0;
    tick();
    check("sh_dmw_t3",   {31'd0, dm_waitrequest}, 32'd1);
    check("sh_mem12",    mem[12],                 32'h00003344);

    // Simultaneous fetch and load: data first, fetch bus read at t+5
    if_address    = 32'hBFC00004;
    if_read       = 1'b1;
    dm_address    = 32'hBFC00008;
    dm_byteenable = 4'b1111;
    dm_read       = 1'b1;
    tick();
    check("sim_read_t1", {31'd0, read},           32'd1);
    check("sim_addr_t1", address,                 32'hBFC00008);
    tick();
    tick();
    check("sim_dmw_t3",  {31'd0, dm_waitrequest}, 32'd0);
    check("sim_dmrd_t3", dm_readdata,             32'hDDDD0002);
    check("sim_ifw_t3",  {31'd0, if_waitrequest}, 32'd1);
    dm_read = 1'b0;
    tick();
    check("sim_read_t4", {31'd0, read},           32'd0);
    tick();
    check("sim_read_t5", {31'd0, read},           32'd1);
    check("sim_addr_t5", address,                 32'hBFC00004);
    tick();
    tick();
    check("sim_ifw_t7",  {31'd0, if_waitrequest}, 32'd0);
    check("sim_ifrd_t7", if_readdata,             32'hAAAA0001);
    if_read = 1'b0;
    tick();

    // Read+write together acts as a write; zero byteenable forwarded as zero
    dm_address    = 32'hBFC00014;
    dm_writedata  = 32'hFFFFFFFF;
    dm_byteenable = 4'b0000;
    dm_read       = 1'b1;
    dm_write      = 1'b1;
    tick();
    check("be0_write_t1", {31'd0, write},          32'd1);
    check("be0_read_t1",  {31'd0, read},           32'd0);
    check("be0_be_t1",    {28'd0, byteenable},     32'd0);
    tick();
    check("be0_dmw_t2",   {31'd0, dm_waitrequest}, 32'd0);
    dm_read  = 1'b0;
    dm_write = 1'b0;
    tick();
    check("be0_mem5",     mem[5],                  32'd0);

    // Starvation guard: 4 data grants, 1 fetch, then data again
    if_address    = 32'hBFC00004;
    if_read       = 1'b1;
    dm_address    = 32'hBFC00008;
    dm_byteenable = 4'b1111;
    dm_read       = 1'b1;
    n_rec         = 0;
    prev_read     = 1'b0;
    for (int i = 0; i < 80 && n_rec < 6; i++) begin
      tick();
      if (read && !prev_read) begin
        rec[n_rec] = address;
        n_rec++;
      end
      prev_read = read;
    end
    check("starve_count", n_rec, 32'd6);
    for (int i = 0; i < n_rec; i++)
      check($sformatf("starve_grant%0d", i), rec[i], (i == 4) ? 32'hBFC00004 : 32'hBFC00008);
    if_read = 1'b0;
    dm_read = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Stall: three waitrequest cycles on a data read
    dm_address  = 32'hBFC0000C;
    dm_read     = 1'b1;
    waitrequest = 1'b1;
    tick();
    check("st_read_t1", {31'd0, read}, 32'd1);
    check("st_addr_t1", address,       32'hBFC0000C);
    tick();
    check("st_read_t2", {31'd0, read}, 32'd1);
    check("st_addr_t2", address,       32'hBFC0000C);
    tick();
    check("st_read_t3", {31'd0, read}, 32'd1);
    check("st_addr_t3", address,       32'hBFC0000C);
    tick();
    check("st_read_t4", {31'd0, read}, 32'd1);
    check("st_addr_t4", address,       32'hBFC0000C);
    waitrequest = 1'b0;
    tick();
    check("st_read_t5", {31'd0, read},           32'd0);
    check("st_dmw_t5",  {31'd0, dm_waitrequest}, 32'd1);
    tick();
    check("st_dmw_t6",  {31'd0, dm_waitrequest}, 32'd0);
    check("st_dmrd_t6", dm_readdata,             32'h5555AAAA);
    dm_read = 1'b0;
    tick();
    check("st_dmw_t7",  {31'd0, dm_waitrequest}, 32'd1);

    // Reset during a stalled fetch: no completion afterwards
    if_address  = 32'hBFC00000;
    if_read     = 1'b1;
    waitrequest = 1'b1;
    tick();
    check("rm_read_t1", {31'd0, read}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("rm_read",   {31'd0, read},           32'd0);
    check("rm_ifw",    {31'd0, if_waitrequest}, 32'd1);
    check("rm_dmw",    {31'd0, dm_waitrequest}, 32'd1);
    check("rm_addr",   address,                 32'd0);
    check("rm_dmrd",   dm_readdata,             32'd0);
    reset       = 1'b0;
    if_read     = 1'b0;
    waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rm_nopulse%0d", i), {31'd0, if_waitrequest}, 32'd1);
      check($sformatf("rm_idle%0d", i),    {31'd0, read},           32'd0);
    end

    // Fresh write after reset shows the arbiter is back in IDLE
    dm_address    = 32'hBFC00018;
    dm_writedata  = 32'h12345678;
    dm_byteenable = 4'b1111;
    dm_write      = 1'b1;
    tick();
    check("pw_write_t1", {31'd0, write},          32'd1);
    check("pw_addr_t1",  address,                 32'hBFC00018);
    tick();
    check("pw_dmw_t2",   {31'd0, dm_waitrequest}, 32'd0);
    dm_write = 1'b0;
    tick();
    check("pw_mem6",     mem[6],                  32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Shares the single Avalon-style memory bus of `mips_cpu_bus` between the instruction-fetch requester and the data-memory (load/store) requester. Each transaction is latched, driven onto the bus with registered outputs, held through `waitrequest` stalls, and completed back to the winning requester with captured read data. Arbitration gives data priority, with a starvation guard for fetch.

## Interface
- `MAX_DATA_RUN`, default 4: consecutive data grants allowed while fetch is pending before fetch must be granted.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `if_address` in 32: fetch byte address.
- `if_read` in 1: fetch request.
- `if_waitrequest` out 1: low for exactly one cycle when the fetch completes.
- `if_readdata` out 32: fetched word, valid while `if_waitrequest`=0.
- `dm_address` in 32: data byte address.
- `dm_read`, `dm_write` in 1 each: data read and write requests.
- `dm_writedata` in 32: store data.
- `dm_byteenable` in 4: lane enables, passed through unchanged.
- `dm_waitrequest` out 1: low for exactly one cycle on completion.
- `dm_readdata` out 32: load word, valid while `dm_waitrequest`=0.
- `address` out 32: bus address.
- `read`, `write` out 1 each: bus strobes.
- `writedata` out 32: bus write data.
- `byteenable` out 4: bus byte enables.
- `waitrequest` in 1: bus stall.
- `readdata` in 32: valid the cycle after an accepted read.

## Operation
- FSM states: IDLE, ISSUE, RDATA, DONE. Reset enters IDLE.
- IDLE:
  - If `dm_read|dm_write` and (`if_read`=0 or run count < `MAX_DATA_RUN`), grant dm.
  - Otherwise, if `if_read`, grant if.
  - On a grant, latch address, writedata, byteenable and the operation into registers, then go to ISSUE.
  - dm with both read and write asserted is treated as a write.
  - If `dm_byteenable`=4'b0000, it is forwarded as 4'b0000, not rewritten.
- ISSUE:
  - Drives the latched request; `read` or `write`=1.
  - Holds all bus outputs stable while `waitrequest`=1.
  - When `waitrequest`=0 at the edge: a read goes to RDATA, a write goes to DONE.
  - `read`/`write` deassert on leaving ISSUE.
- RDATA: the bus is idle. Captures `readdata` into the granted port's readdata register at the end of the cycle, then goes to DONE.
- DONE: the granted port's waitrequest=0 for one cycle, then go to IDLE. Requests are not sampled in DONE.
- Run counter:
  - Increments on each dm grant made while `if_read`=1.
  - Clears on an if grant, or on a dm grant made while `if_read`=0.
  - Saturates at `MAX_DATA_RUN`.
- Requester inputs changing after the grant are ignored until IDLE.
- The non-granted port keeps waitrequest=1 throughout.

## Timing
- Reset values:
  - `read`, `write` = 0.
  - `address`, `writedata`, `if_readdata`, `dm_readdata` = 0.
  - `byteenable` = 0.
  - `if_waitrequest`, `dm_waitrequest` = 1.
  - Run counter = 0.
- Read, zero stalls: request seen at cycle t (IDLE); bus `read` at t+1; capture at t+2; port waitrequest=0 at t+3. Latency is 3 cycles from request to completion.
- Write, zero stalls: bus `write` at t+1; port waitrequest=0 at t+2.
- Each `waitrequest`=1 cycle in ISSUE adds one cycle; bus outputs stay unchanged across stalls.
- Back-to-back: the next grant is evaluated in IDLE at t+4 (read) or t+3 (write). There is at least one idle bus cycle between transactions.
- Port readdata registers hold their value until the next read completes on that port.
- Reset asserted in any state: next cycle in IDLE with reset values on all outputs. No completion pulse is issued for an aborted transaction.

## Test plan
- Fetch only:
  - Stimulus: `if_read`, `if_address`=0xBFC00000, memory word 0x3C08BFC0, `waitrequest`=0.
  - Required: bus `read`=1 at t+1 only, `address`=0xBFC00000, `if_waitrequest`=0 at t+3 only, `if_readdata`=0x3C08BFC0.
- Store halfword:
  - Stimulus: `dm_write`, `dm_address`=0xBFC00030, `dm_writedata`=0x0000A3F3, `dm_byteenable`=4'b1100.
  - Required: bus `write`=1, `byteenable`=4'b1100 at t+1; `dm_waitrequest`=0 at t+2; memory word 12 updated accordingly.
- Simultaneous requests:
  - Stimulus: `if_read` and `dm_read` asserted together.
  - Required: dm served first; if served next, its bus `read` at t+5.
- Starvation guard, `MAX_DATA_RUN`=4:
  - Stimulus: dm requests continuously alongside `if_read`.
  - Required: exactly 4 dm transactions, then 1 fetch, then dm resumes.
- Stall:
  - Stimulus: `waitrequest`=1 for 3 cycles on a dm read.
  - Required: `read`/`address` stable for 4 cycles; completion 3 cycles later than unstalled.
- Reset mid-operation:
  - Stimulus: assert `reset` during ISSUE with `waitrequest`=1.
  - Required: next cycle `read`=0, both port waitrequests=1, FSM in IDLE, no completion pulse.
